// File: rtl/utim64_irq_ctrl_pkg.sv
// ============================================================================
// Module  : utim64_irq_ctrl_pkg
// Purpose : Register map, STAT layout and FSM encoding for the utim64 IRQ
//           front-end.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package utim64_irq_ctrl_pkg;

    localparam logic [1:0] UTIM64_IRQ_MASK = 2'd0;
    localparam logic [1:0] UTIM64_IRQ_PEND = 2'd1;
    localparam logic [1:0] UTIM64_IRQ_STAT = 2'd2;
    localparam logic [1:0] UTIM64_IRQ_OVF  = 2'd3;

    localparam int UTIM64_IRQ_STAT_VALID_BIT = 0;
    localparam int UTIM64_IRQ_STAT_NUM_LSB   = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } irq_state_t;

endpackage

`default_nettype wire

// File: rtl/utim64_irq_prienc.sv
// ============================================================================
// Module  : utim64_irq_prienc
// Purpose : Combinational lowest-index-wins priority encoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module utim64_irq_prienc #(
    parameter int P_CH    = 4,
    parameter int P_NUM_W = 2
) (
    input  logic [P_CH-1:0]    iVEC,
    output logic               oFOUND,
    output logic [P_NUM_W-1:0] oIDX
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        oFOUND = 1'b0;
        oIDX   = '0;
        for (int i = P_CH - 1; i >= 0; i--) begin
            if (iVEC[i]) begin
                oFOUND = 1'b1;
                oIDX   = P_NUM_W'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/utim64_irq_ctrl.sv
// ============================================================================
// Module  : utim64_irq_ctrl
// Purpose : Edge-detects utim64 comparator IRQs into sticky pending bits and
//           delivers them one at a time over a valid/ack handshake.
//           Optional lost-event counters: define UTIM64_IRQ_OVF_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module utim64_irq_ctrl
    import utim64_irq_ctrl_pkg::*;
#(
    parameter int P_CH    = 4,
    parameter int P_NUM_W = 2,
    parameter int P_OVF_W = 8
) (
    input  logic               iCLOCK,
    input  logic               iRESET,
    input  logic [P_CH-1:0]    iTIMER_IRQ,
    input  logic               iREQ_VALID,
    input  logic               iREQ_RW,
    input  logic [1:0]         iREQ_ADDR,
    input  logic [31:0]        iREQ_DATA,
    output logic               oREQ_VALID,
    output logic [31:0]        oREQ_DATA,
    output logic               oIRQ_VALID,
    output logic [P_NUM_W-1:0] oIRQ_NUM,
    input  logic               iIRQ_ACK
);

    logic [P_CH-1:0]    r_prev;
    logic [P_CH-1:0]    r_pend;
    logic [P_CH-1:0]    r_mask;
    irq_state_t         r_state;
    logic               r_irq_valid;
    logic [P_NUM_W-1:0] r_irq_num;
    logic               r_rd_valid;
    logic [31:0]        r_rd_data;

    logic [P_CH-1:0]    w_event;
    logic [P_CH-1:0]    w_ack_clr;
    logic [P_CH-1:0]    w_w1c;
    logic               w_rd;
    logic               w_wr;
    logic               w_found;
    logic [P_NUM_W-1:0] w_idx;
    logic [31:0]        w_stat;
    logic [31:0]        w_ovf_rd;
    logic [31:0]        w_rd_mux;
    logic               w_unused_data;

    assign w_event       = iTIMER_IRQ & ~r_prev;
    assign w_rd          = iREQ_VALID & ~iREQ_RW;
    assign w_wr          = iREQ_VALID & iREQ_RW;
    assign w_w1c         = (w_wr && iREQ_ADDR == UTIM64_IRQ_PEND) ? iREQ_DATA[P_CH-1:0] : '0;
    assign w_unused_data = ^iREQ_DATA[31:P_CH];

    always_comb begin
        w_ack_clr = '0;
        if (r_state == ISSUE && iIRQ_ACK)
            w_ack_clr[r_irq_num] = 1'b1;
    end

    utim64_irq_prienc #(
        .P_CH    (P_CH),
        .P_NUM_W (P_NUM_W)
    ) u_prienc (
        .iVEC   (r_pend & r_mask),
        .oFOUND (w_found),
        .oIDX   (w_idx)
    );

    always_comb begin
        w_stat = '0;
        w_stat[UTIM64_IRQ_STAT_VALID_BIT] = r_irq_valid;
        w_stat[UTIM64_IRQ_STAT_NUM_LSB +: P_NUM_W] = r_irq_num;
    end

`ifdef UTIM64_IRQ_OVF_CNT_EN
    logic [P_OVF_W-1:0] r_ovf [P_CH];
    logic               w_ovf_clr;

    assign w_ovf_clr = w_wr && (iREQ_ADDR == UTIM64_IRQ_OVF);

    // A lost event is a new edge on a channel whose pending bit is still set.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            for (int i = 0; i < P_CH; i++) r_ovf[i] <= '0;
        end else if (w_ovf_clr) begin
            for (int i = 0; i < P_CH; i++) r_ovf[i] <= '0;
        end else begin
            for (int i = 0; i < P_CH; i++)
                if (w_event[i] && r_pend[i] && r_ovf[i] != '1)
                    r_ovf[i] <= r_ovf[i] + 1'b1;
        end
    end

    always_comb begin
        w_ovf_rd = '0;
        for (int i = 0; i < P_CH; i++)
            w_ovf_rd[i*P_OVF_W +: P_OVF_W] = r_ovf[i];
    end
`else
    logic [P_OVF_W-1:0] w_unused_ovf;
    assign w_unused_ovf = '0;
    assign w_ovf_rd     = '0;
`endif

    always_comb begin
        case (iREQ_ADDR)
            UTIM64_IRQ_MASK: w_rd_mux = 32'(r_mask);
            UTIM64_IRQ_PEND: w_rd_mux = 32'(r_pend);
            UTIM64_IRQ_STAT: w_rd_mux = w_stat;
            default:         w_rd_mux = w_ovf_rd;
        endcase
    end

    // Pending: a fresh edge always beats either clear source.
    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_prev     <= '0;
            r_pend     <= '0;
            r_mask     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_prev     <= iTIMER_IRQ;
            r_pend     <= (r_pend & ~(w_ack_clr | w_w1c)) | w_event;
            r_rd_valid <= w_rd;
            if (w_wr && iREQ_ADDR == UTIM64_IRQ_MASK)
                r_mask <= iREQ_DATA[P_CH-1:0];
            if (w_rd)
                r_rd_data <= w_rd_mux;
        end
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            r_state     <= IDLE;
            r_irq_valid <= 1'b0;
            r_irq_num   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_irq_num   <= w_idx;
                        r_irq_valid <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (iIRQ_ACK) begin
                        r_irq_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_irq_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign oREQ_VALID = r_rd_valid;
    assign oREQ_DATA  = r_rd_data;
    assign oIRQ_VALID = r_irq_valid;
    assign oIRQ_NUM   = r_irq_num;

endmodule

`default_nettype wire
